cycle_request_arbiter: RTL and testbench
========================================

CYCLE_REQUEST_ARBITER -- requirements
Module: cycle_request_arbiter

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
  Clk  in  1  sole clock; all state changes on its rising edge.
  Reset  in  1  asynchronous, active-high block reset.
  InstrEnd  in  1  instruction-boundary strobe from the sequencer.
  SeqDone  in  1  strobe: the current service sequence (NMI or INT) is finished.
  Req_Reset  in  1  synchronised CPU reset request; level.
  Req_Busrq  in  1  bus request; level.
  Req_Nmi  in  1  NMI line; the rising edge is significant.
  Req_Int  in  1  maskable interrupt; level.
  IFF1  in  1  interrupt enable flag.
  IM  in  2  interrupt mode.
  AckDataValid  in  1  IM0 acknowledge opcode is classified.
  Int0_IsRst  in  1  IM0 opcode is RST; qualified by AckDataValid.
  Int0_IsCall  in  1  IM0 opcode is CALL; qualified by AckDataValid.
  P2_Set_CM1, P2_Set_CRESET, P2_Set_CBUSRQ, P2_Set_CNMI  out  1 each  set pulses to the control flip-flops.
  P2_Set_CINT0, P2_Set_CINT0_RST, P2_Set_CINT0_CALL, P2_Set_CINT1, P2_Set_CINT2  out  1 each  set pulses to the control flip-flops.
  P2_Reset_CRESET, P2_Reset_CBUSRQ, P2_Reset_CNMI, P2_Reset_CINT, P2_Reset_ALLUNOFFICIALFF  out  1 each  reset pulses to the control flip-flops.
  Busy  out  1  state is not IDLE.
  NmiPending  out  1  latched NMI edge that has not yet been serviced.
REQ-002 SHALL use one clock, Clk; Reset SHALL be asynchronous and active-high.

Function
REQ-003 All P2_* outputs SHALL be registered, one-cycle pulses. A decision at edge N SHALL drive the pulse high for the cycle following edge N.
REQ-004 The FSM SHALL have these states: IDLE, RESET_SVC, BUS_HOLD, NMI_SVC, INT_ACK, INT_SVC.
REQ-005 NMI edge latch: a rising edge of Req_Nmi SHALL set NmiPending. Entry to NMI_SVC or RESET_SVC SHALL clear it.
REQ-006 If an NMI edge and entry to NMI_SVC occur in the same cycle, NmiPending SHALL remain set.
REQ-007 Req_Reset=1 in any state SHALL force RESET_SVC on the next edge. On that entry the block SHALL pulse P2_Set_CRESET and P2_Reset_ALLUNOFFICIALFF together.
REQ-008 RESET_SVC SHALL hold while Req_Reset=1. When Req_Reset falls, the block SHALL pulse P2_Reset_CRESET and go to IDLE.
REQ-009 In IDLE, the block SHALL arbitrate only when InstrEnd=1, with fixed priority BUSRQ > NMI (NmiPending) > INT (Req_Int & IFF1).
REQ-010 In IDLE with InstrEnd=1 and no request granted, the block SHALL pulse P2_Set_CM1 and remain in IDLE.
REQ-011 BUSRQ grant: the block SHALL pulse P2_Set_CBUSRQ and enter BUS_HOLD. It SHALL hold while Req_Busrq=1. On release it SHALL pulse P2_Reset_CBUSRQ and go to IDLE.
REQ-012 NMI grant: the block SHALL pulse P2_Set_CNMI and enter NMI_SVC. On SeqDone it SHALL pulse P2_Reset_CNMI and go to IDLE.
REQ-013 INT grant: the block SHALL enter INT_ACK and pulse P2_Set_CINT0 for IM=0 or IM=3, P2_Set_CINT1 for IM=1, or P2_Set_CINT2 for IM=2.
REQ-014 IM is sampled at grant. Changes to IM while in INT_ACK or INT_SVC SHALL be ignored.
REQ-015 INT_ACK with IM1 or IM2: the block SHALL go to INT_SVC on the next edge.
REQ-016 INT_ACK with IM0: the block SHALL wait for AckDataValid, then pulse P2_Set_CINT0_RST if Int0_IsRst, else P2_Set_CINT0_CALL if Int0_IsCall, else neither, and go to INT_SVC.
REQ-017 If Int0_IsRst and Int0_IsCall are both high, RST SHALL win.
REQ-018 INT_SVC on SeqDone: the block SHALL pulse P2_Reset_CINT and go to IDLE.
REQ-019 InstrEnd outside IDLE SHALL be ignored.
REQ-020 SeqDone outside NMI_SVC and INT_SVC SHALL be ignored.
REQ-021 If SeqDone and InstrEnd are high in the same cycle, the block SHALL return to IDLE first. No arbitration SHALL occur in that cycle.
REQ-022 At most one P2_Set_* SHALL pulse per cycle, except that P2_Set_CRESET and P2_Reset_ALLUNOFFICIALFF pulse together.

Reset
REQ-023 Reset=1 SHALL immediately force IDLE, clear NmiPending, set Busy=0, and drive every P2_* output to 0.
REQ-024 Reset mid-service SHALL abandon the sequence without issuing any P2_Reset_* pulse.

Structure
REQ-025 A shared package SHALL hold the state enumeration, the IM encodings (IM0=0, IM1=1, IM2=2, IM3 aliases IM0), and the priority order.
REQ-026 The NMI edge latch SHALL be a separate sub-module, nmi_edge_latch. The FSM and pulse registers SHALL stay in cycle_request_arbiter.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - Idle: InstrEnd=1 with no requests -> P2_Set_CM1 one cycle later; Busy=0.
  - Priority: Req_Busrq=1, NMI edge, and Req_Int=1 with IFF1=1 at InstrEnd -> P2_Set_CBUSRQ. After Req_Busrq drops -> P2_Reset_CBUSRQ. Next InstrEnd -> P2_Set_CNMI.
  - IM0 RST: IFF1=1, IM=0, Req_Int=1, InstrEnd -> P2_Set_CINT0. Then AckDataValid=1 with Int0_IsRst=1 three cycles later -> P2_Set_CINT0_RST. SeqDone -> P2_Reset_CINT.
  - Masked: IFF1=0 with Req_Int=1 at InstrEnd -> P2_Set_CM1 only.
  - Reset request: Req_Reset=1 during INT_SVC -> P2_Set_CRESET and P2_Reset_ALLUNOFFICIALFF in the same cycle, NmiPending=0. Req_Reset=0 -> P2_Reset_CRESET, then IDLE.
  - Block reset: Reset asserted mid-NMI_SVC -> all outputs 0 immediately, and no P2_Reset_CNMI pulse.

Source files
------------

// File: rtl/cycle_request_arbiter_pkg.sv
// Shared definitions for the cycle request arbiter: FSM state encoding,
// interrupt-mode encodings, grant priority order and the P2 pulse bundle.
// Ports: none (package).
package cycle_request_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_SVC,
    ST_BUS_HOLD,
    ST_NMI_SVC,
    ST_INT_ACK,
    ST_INT_SVC
  } state_e;

  // Interrupt modes; IM3 behaves exactly like IM0.
  localparam logic [1:0] IM0 = 2'd0;
  localparam logic [1:0] IM1 = 2'd1;
  localparam logic [1:0] IM2 = 2'd2;
  localparam logic [1:0] IM3 = 2'd3;

  // Grant outcomes; the arbitrate() function below fixes the priority order.
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_BUSRQ,
    GRANT_NMI,
    GRANT_INT
  } grant_e;

  // One-cycle pulses towards the control flip-flops.
  typedef struct packed {
    logic set_cm1;
    logic set_creset;
    logic set_cbusrq;
    logic set_cnmi;
    logic set_cint0;
    logic set_cint0_rst;
    logic set_cint0_call;
    logic set_cint1;
    logic set_cint2;
    logic reset_creset;
    logic reset_cbusrq;
    logic reset_cnmi;
    logic reset_cint;
    logic reset_allunofficialff;
  } p2_t;

  function automatic logic [1:0] im_norm(input logic [1:0] im);
    return (im == IM3) ? IM0 : im;
  endfunction

  // Fixed priority: bus request > NMI > maskable interrupt.
  function automatic grant_e arbitrate(input logic busrq, input logic nmi, input logic intr);
    if (busrq)     return GRANT_BUSRQ;
    else if (nmi)  return GRANT_NMI;
    else if (intr) return GRANT_INT;
    else           return GRANT_NONE;
  endfunction

endpackage

// File: rtl/cycle_request_arbiter_nmi_latch.sv
// NMI rising-edge latch: remembers an NMI edge until the arbiter takes it.
// Ports: clk_i/rst_i (async active-high), nmi_i raw NMI level, clr_i clear
// strobe on service entry, pending_o latched edge.
module nmi_edge_latch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic nmi_i,
  input  logic clr_i,
  output logic pending_o
);

  logic nmi_prev_q;
  logic pending_q;
  logic pending_d;
  logic nmi_rise;

  assign nmi_rise = nmi_i & ~nmi_prev_q;

  // A fresh edge beats a simultaneous clear so that an NMI arriving in the
  // very cycle an earlier one is taken is not lost.
  always_comb begin
    pending_d = pending_q;
    if (nmi_rise)   pending_d = 1'b1;
    else if (clr_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nmi_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_i;
      pending_q  <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/cycle_request_arbiter.sv
// Cycle request arbiter: at instruction boundaries picks bus request, NMI or
// maskable interrupt and sequences their service, emitting registered
// one-cycle P2_* set/reset pulses to the CPU control flip-flops.
// Ports: Clk/Reset (async active-high); sequencer strobes InstrEnd, SeqDone;
// requests Req_Reset, Req_Busrq, Req_Nmi, Req_Int with IFF1 and IM; IM0
// acknowledge classification AckDataValid/Int0_IsRst/Int0_IsCall;
// outputs P2_* pulses, Busy and NmiPending.
module cycle_request_arbiter
  import cycle_request_arbiter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       InstrEnd,
  input  logic       SeqDone,
  input  logic       Req_Reset,
  input  logic       Req_Busrq,
  input  logic       Req_Nmi,
  input  logic       Req_Int,
  input  logic       IFF1,
  input  logic [1:0] IM,
  input  logic       AckDataValid,
  input  logic       Int0_IsRst,
  input  logic       Int0_IsCall,
  output logic       P2_Set_CM1,
  output logic       P2_Set_CRESET,
  output logic       P2_Set_CBUSRQ,
  output logic       P2_Set_CNMI,
  output logic       P2_Set_CINT0,
  output logic       P2_Set_CINT0_RST,
  output logic       P2_Set_CINT0_CALL,
  output logic       P2_Set_CINT1,
  output logic       P2_Set_CINT2,
  output logic       P2_Reset_CRESET,
  output logic       P2_Reset_CBUSRQ,
  output logic       P2_Reset_CNMI,
  output logic       P2_Reset_CINT,
  output logic       P2_Reset_ALLUNOFFICIALFF,
  output logic       Busy,
  output logic       NmiPending
);

  state_e     state_q;
  logic [1:0] im_q;
  p2_t        p2_q;
  grant_e     grant;
  logic       nmi_pending;
  logic       nmi_clr;
  logic       enter_reset;
  logic       enter_nmi;

  assign grant = arbitrate(Req_Busrq, nmi_pending, Req_Int & IFF1);

  // Entry conditions mirror the FSM transitions below; the latch is cleared
  // on the same edge the FSM enters the service state.
  assign enter_reset = Req_Reset && (state_q != ST_RESET_SVC);
  assign enter_nmi   = !Req_Reset && (state_q == ST_IDLE) && InstrEnd && (grant == GRANT_NMI);
  assign nmi_clr     = enter_reset | enter_nmi;

  nmi_edge_latch u_nmi_edge_latch (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .nmi_i     (Req_Nmi),
    .clr_i     (nmi_clr),
    .pending_o (nmi_pending)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      im_q    <= IM0;
      p2_q    <= '0;
    end else begin
      p2_q <= '0;
      if (Req_Reset) begin
        // CPU reset pre-empts everything; pulses only on entry.
        if (state_q != ST_RESET_SVC) begin
          state_q                    <= ST_RESET_SVC;
          p2_q.set_creset            <= 1'b1;
          p2_q.reset_allunofficialff <= 1'b1;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (InstrEnd) begin
              unique case (grant)
                GRANT_BUSRQ: begin
                  p2_q.set_cbusrq <= 1'b1;
                  state_q         <= ST_BUS_HOLD;
                end
                GRANT_NMI: begin
                  p2_q.set_cnmi <= 1'b1;
                  state_q       <= ST_NMI_SVC;
                end
                GRANT_INT: begin
                  // IM is captured here and frozen for the whole sequence.
                  im_q    <= im_norm(IM);
                  state_q <= ST_INT_ACK;
                  case (im_norm(IM))
                    IM1:     p2_q.set_cint1 <= 1'b1;
                    IM2:     p2_q.set_cint2 <= 1'b1;
                    default: p2_q.set_cint0 <= 1'b1;
                  endcase
                end
                default: p2_q.set_cm1 <= 1'b1;
              endcase
            end
          end
          ST_RESET_SVC: begin
            p2_q.reset_creset <= 1'b1;
            state_q           <= ST_IDLE;
          end
          ST_BUS_HOLD: begin
            if (!Req_Busrq) begin
              p2_q.reset_cbusrq <= 1'b1;
              state_q           <= ST_IDLE;
            end
          end
          ST_NMI_SVC: begin
            if (SeqDone) begin
              p2_q.reset_cnmi <= 1'b1;
              state_q         <= ST_IDLE;
            end
          end
          ST_INT_ACK: begin
            if (im_q != IM0) begin
              state_q <= ST_INT_SVC;
            end else if (AckDataValid) begin
              // RST classification wins over CALL.
              if (Int0_IsRst)       p2_q.set_cint0_rst  <= 1'b1;
              else if (Int0_IsCall) p2_q.set_cint0_call <= 1'b1;
              state_q <= ST_INT_SVC;
            end
          end
          ST_INT_SVC: begin
            if (SeqDone) begin
              p2_q.reset_cint <= 1'b1;
              state_q         <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign P2_Set_CM1               = p2_q.set_cm1;
  assign P2_Set_CRESET            = p2_q.set_creset;
  assign P2_Set_CBUSRQ            = p2_q.set_cbusrq;
  assign P2_Set_CNMI              = p2_q.set_cnmi;
  assign P2_Set_CINT0             = p2_q.set_cint0;
  assign P2_Set_CINT0_RST         = p2_q.set_cint0_rst;
  assign P2_Set_CINT0_CALL        = p2_q.set_cint0_call;
  assign P2_Set_CINT1             = p2_q.set_cint1;
  assign P2_Set_CINT2             = p2_q.set_cint2;
  assign P2_Reset_CRESET          = p2_q.reset_creset;
  assign P2_Reset_CBUSRQ          = p2_q.reset_cbusrq;
  assign P2_Reset_CNMI            = p2_q.reset_cnmi;
  assign P2_Reset_CINT            = p2_q.reset_cint;
  assign P2_Reset_ALLUNOFFICIALFF = p2_q.reset_allunofficialff;
  assign Busy                     = (state_q != ST_IDLE);
  assign NmiPending               = nmi_pending;

endmodule

// File: tb/tb_cycle_request_arbiter.sv
// Self-checking bench for cycle_request_arbiter: table of per-cycle vectors
// plus hand-written asynchronous reset sequence.
// Ports: none (top-level bench).
module tb_cycle_request_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       InstrEnd, SeqDone, Req_Reset, Req_Busrq, Req_Nmi, Req_Int, IFF1;
  logic [1:0] IM;
  logic       AckDataValid, Int0_IsRst, Int0_IsCall;
  logic       P2_Set_CM1, P2_Set_CRESET, P2_Set_CBUSRQ, P2_Set_CNMI, P2_Set_CINT0;
  logic       P2_Set_CINT0_RST, P2_Set_CINT0_CALL, P2_Set_CINT1, P2_Set_CINT2;
  logic       P2_Reset_CRESET, P2_Reset_CBUSRQ, P2_Reset_CNMI, P2_Reset_CINT;
  logic       P2_Reset_ALLUNOFFICIALFF, Busy, NmiPending;

  cycle_request_arbiter dut (
    .Clk(Clk), .Reset(Reset), .InstrEnd(InstrEnd), .SeqDone(SeqDone),
    .Req_Reset(Req_Reset), .Req_Busrq(Req_Busrq), .Req_Nmi(Req_Nmi),
    .Req_Int(Req_Int), .IFF1(IFF1), .IM(IM), .AckDataValid(AckDataValid),
    .Int0_IsRst(Int0_IsRst), .Int0_IsCall(Int0_IsCall),
    .P2_Set_CM1(P2_Set_CM1), .P2_Set_CRESET(P2_Set_CRESET),
    .P2_Set_CBUSRQ(P2_Set_CBUSRQ), .P2_Set_CNMI(P2_Set_CNMI),
    .P2_Set_CINT0(P2_Set_CINT0), .P2_Set_CINT0_RST(P2_Set_CINT0_RST),
    .P2_Set_CINT0_CALL(P2_Set_CINT0_CALL), .P2_Set_CINT1(P2_Set_CINT1),
    .P2_Set_CINT2(P2_Set_CINT2), .P2_Reset_CRESET(P2_Reset_CRESET),
    .P2_Reset_CBUSRQ(P2_Reset_CBUSRQ), .P2_Reset_CNMI(P2_Reset_CNMI),
    .P2_Reset_CINT(P2_Reset_CINT), .P2_Reset_ALLUNOFFICIALFF(P2_Reset_ALLUNOFFICIALFF),
    .Busy(Busy), .NmiPending(NmiPending)
  );

  always #5 Clk = ~Clk;

  // Expected P2 pulse bits, in the order of the obs vector below.
  localparam logic [13:0] CM1     = 14'h2000;
  localparam logic [13:0] CRESET  = 14'h1000;
  localparam logic [13:0] CBUSRQ  = 14'h0800;
  localparam logic [13:0] CNMI    = 14'h0400;
  localparam logic [13:0] CINT0   = 14'h0200;
  localparam logic [13:0] C0RST   = 14'h0100;
  localparam logic [13:0] C0CALL  = 14'h0080;
  localparam logic [13:0] CINT1   = 14'h0040;
  localparam logic [13:0] CINT2   = 14'h0020;
  localparam logic [13:0] R_CRST  = 14'h0010;
  localparam logic [13:0] R_CBUS  = 14'h0008;
  localparam logic [13:0] R_CNMI  = 14'h0004;
  localparam logic [13:0] R_CINT  = 14'h0002;
  localparam logic [13:0] R_ALL   = 14'h0001;
  localparam logic [13:0] NONE    = 14'h0000;

  // Input bits: {InstrEnd,SeqDone,Req_Reset,Req_Busrq,Req_Nmi,Req_Int,IFF1,IM[1:0],AckDataValid,Int0_IsRst,Int0_IsCall}
  localparam logic [11:0] I0   = 12'h000;
  localparam logic [11:0] IE   = 12'h800;
  localparam logic [11:0] SD   = 12'h400;
  localparam logic [11:0] RR   = 12'h200;
  localparam logic [11:0] RB   = 12'h100;
  localparam logic [11:0] RN   = 12'h080;
  localparam logic [11:0] RI   = 12'h040;
  localparam logic [11:0] IFF  = 12'h020;
  localparam logic [11:0] IMS1 = 12'h008;
  localparam logic [11:0] IMS2 = 12'h010;
  localparam logic [11:0] IMS3 = 12'h018;
  localparam logic [11:0] ADV  = 12'h004;
  localparam logic [11:0] ARST = 12'h002;
  localparam logic [11:0] ACAL = 12'h001;

  typedef struct {
    logic [11:0] ins;
    logic [13:0] p2;
    logic        busy;
    logic        nmip;
  } vec_t;

  vec_t        vt[$];
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  wire [15:0] obs = {P2_Set_CM1, P2_Set_CRESET, P2_Set_CBUSRQ, P2_Set_CNMI, P2_Set_CINT0,
                     P2_Set_CINT0_RST, P2_Set_CINT0_CALL, P2_Set_CINT1, P2_Set_CINT2,
                     P2_Reset_CRESET, P2_Reset_CBUSRQ, P2_Reset_CNMI, P2_Reset_CINT,
                     P2_Reset_ALLUNOFFICIALFF, Busy, NmiPending};

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got p2=%h busy=%b nmip=%b, expected p2=%h busy=%b nmip=%b",
               name, got[15:2], got[1], got[0], exp[15:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [11:0] ins);
    {InstrEnd, SeqDone, Req_Reset, Req_Busrq, Req_Nmi, Req_Int, IFF1, IM,
     AckDataValid, Int0_IsRst, Int0_IsCall} = ins;
  endtask

  function automatic void addv(input logic [11:0] ins, input logic [13:0] p2,
                               input logic busy, input logic nmip);
    vt.push_back('{ins, p2, busy, nmip});
  endfunction

  // Called at a negedge: drive, push expectation, let one rising edge pass,
  // then compare at the following negedge.
  task automatic step(input logic [11:0] ins, input logic [13:0] p2, input logic busy,
                      input logic nmip, input string name);
    logic [15:0] e;
    drive(ins);
    exp_q.push_back({p2, busy, nmip});
    @(posedge Clk);
    @(negedge Clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, obs, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Idle and masked interrupt
    addv(IE,                 CM1,    0, 0);
    addv(I0,                 NONE,   0, 0);
    addv(IE|RI,              CM1,    0, 0);
    // Priority: BUSRQ beats NMI and INT, then NMI beats INT
    addv(IE|RB|RN|RI|IFF,    CBUSRQ, 1, 1);
    addv(RB|RN|RI|IFF,       NONE,   1, 1);
    addv(IE|RB|RI|IFF,       NONE,   1, 1);
    addv(RI|IFF,             R_CBUS, 0, 1);
    addv(IE|RI|IFF,          CNMI,   1, 0);
    addv(I0,                 NONE,   1, 0);
    addv(SD|IE,              R_CNMI, 0, 0);
    addv(I0,                 NONE,   0, 0);
    // NMI edge coinciding with NMI_SVC entry keeps the latch set
    addv(RN,                 NONE,   0, 1);
    addv(I0,                 NONE,   0, 1);
    addv(IE|RN,              CNMI,   1, 1);
    addv(SD,                 R_CNMI, 0, 1);
    addv(IE,                 CNMI,   1, 0);
    addv(SD,                 R_CNMI, 0, 0);
    // IM0 with RST (and CALL) classification, IM change ignored
    addv(IE|RI|IFF,          CINT0,  1, 0);
    addv(RI|IFF|IMS1,        NONE,   1, 0);
    addv(I0,                 NONE,   1, 0);
    addv(ADV|ARST|ACAL,      C0RST,  1, 0);
    addv(I0,                 NONE,   1, 0);
    addv(SD,                 R_CINT, 0, 0);
    // IM3 aliases IM0, CALL classification
    addv(IE|RI|IFF|IMS3,     CINT0,  1, 0);
    addv(ADV|ACAL,           C0CALL, 1, 0);
    addv(SD,                 R_CINT, 0, 0);
    // IM0 with neither RST nor CALL
    addv(IE|RI|IFF,          CINT0,  1, 0);
    addv(ADV,                NONE,   1, 0);
    addv(SD,                 R_CINT, 0, 0);
    // IM1: SeqDone in INT_ACK ignored
    addv(IE|RI|IFF|IMS1,     CINT1,  1, 0);
    addv(SD|IMS2,            NONE,   1, 0);
    addv(SD,                 R_CINT, 0, 0);
    // IM2: ack data ignored
    addv(IE|RI|IFF|IMS2,     CINT2,  1, 0);
    addv(ADV|ARST,           NONE,   1, 0);
    addv(SD,                 R_CINT, 0, 0);
    // Reset request during INT_SVC with an NMI pending
    addv(IE|RI|IFF|IMS1,     CINT1,  1, 0);
    addv(RN,                 NONE,   1, 1);
    addv(RR,                 CRESET|R_ALL, 1, 0);
    addv(RR,                 NONE,   1, 0);
    addv(IE|RB,              R_CRST, 0, 0);
    addv(I0,                 NONE,   0, 0);
    // Reset request from IDLE overrides InstrEnd
    addv(RR|IE,              CRESET|R_ALL, 1, 0);
    addv(I0,                 R_CRST, 0, 0);

    Reset = 1'b1;
    drive(I0);
    #12;
    check("reset_state", obs, 16'h0000);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < vt.size(); i++)
      step(vt[i].ins, vt[i].p2, vt[i].busy, vt[i].nmip, $sformatf("vec%0d", i));

    // Block reset in the middle of NMI service
    step(RN, NONE, 0, 1, "blk_nmi_edge");
    step(IE, CNMI, 1, 0, "blk_nmi_grant");
    step(I0, NONE, 1, 0, "blk_nmi_svc");
    Reset = 1'b1;
    #1;
    check("blk_reset_immediate", obs, 16'h0000);
    drive(SD);
    @(posedge Clk);
    @(negedge Clk);
    check("blk_reset_held", obs, 16'h0000);
    Reset = 1'b0;
    step(SD, NONE, 0, 0, "blk_no_reset_cnmi");
    step(IE, CM1,  0, 0, "blk_idle_after");

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
